// File: rtl/cla_sub_serial.sv
// Serial 64-bit subtractor: one lookahead slice of SLICE_W bits per cycle, valid/ready on both sides.
// Define CLA_SUB_OVF_EN to add the registered signed-overflow output ovf.
module cla_sub_serial #(
  parameter int unsigned SLICE_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] diff,
  output logic        borrow
`ifdef CLA_SUB_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam int unsigned NSLICE = 64 / SLICE_W;
  localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [63:0]         a_q, nb_q;
  logic                carry;
  logic [KW-1:0]       k;
  logic [SLICE_W-1:0]  sa, snb, g, kl, p, sum;
  logic [SLICE_W:0]    c;
  logic [63+SLICE_W:0] diff_cat;

  // Operands shift down one slice per cycle, so the active slice is always the low bits;
  // results enter diff from the top and reach their final position after NSLICE cycles.
  assign sa       = a_q[SLICE_W-1:0];
  assign snb      = nb_q[SLICE_W-1:0];
  assign g        = sa & snb;
  assign kl       = ~sa & ~snb;
  assign p        = ~(g | kl);
  assign sum      = p ^ c[SLICE_W-1:0];
  assign diff_cat = {sum, diff};

  // Each carry is a flat sum of products over generate/propagate terms and the carry-in.
  always_comb begin
    logic cc, pp;
    c    = '0;
    c[0] = carry;
    for (int unsigned i = 0; i < SLICE_W; i++) begin
      cc = 1'b0;
      pp = 1'b1;
      for (int unsigned j = 0; j <= i; j++) begin
        cc = cc | (g[i-j] & pp);
        pp = pp & p[i-j];
      end
      c[i+1] = cc | (pp & carry);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (k == K_LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      nb_q   <= '0;
      carry  <= 1'b0;
      k      <= '0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef CLA_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= a;
          nb_q  <= ~b;
          carry <= 1'b1;
          k     <= '0;
          diff  <= '0;
        end
        RUN: begin
          a_q   <= a_q >> SLICE_W;
          nb_q  <= nb_q >> SLICE_W;
          diff  <= diff_cat[63+SLICE_W:SLICE_W];
          carry <= c[SLICE_W];
          k     <= k + 1'b1;
          if (k == K_LAST) begin
            borrow <= ~c[SLICE_W];
`ifdef CLA_SUB_OVF_EN
            // Top slice holds a[63] and ~b[63]; equal means the operand signs differ.
            ovf    <= (sa[SLICE_W-1] == snb[SLICE_W-1]) && (sum[SLICE_W-1] != sa[SLICE_W-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_sub_serial.sv
// Scoreboard bench for cla_sub_serial: directed vectors on an 8-bit-slice instance,
// plus back-to-back random traffic on 16- and 64-bit-slice instances.
module tb_cla_sub_serial;

  localparam int unsigned SW = 8;
  localparam int unsigned NS = 64 / SW;

  typedef struct packed {
    logic [63:0] d;
    logic        bw;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, borrow;
  logic [63:0] a, b, diff;
`ifdef CLA_SUB_OVF_EN
  logic        ovf;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t me;

  always #5 clk = ~clk;

  cla_sub_serial #(.SLICE_W(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow)
`ifdef CLA_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  function automatic void chk(input bit ok, input string name,
                              input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endfunction

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_result", diff, 64'd0);
      end else begin
        me = sb.pop_front();
        chk(diff === me.d, "diff", diff, me.d);
        chk(borrow === me.bw, "borrow", {63'd0, borrow}, {63'd0, me.bw});
`ifdef CLA_SUB_OVF_EN
        chk(ovf === me.ov, "ovf", {63'd0, ovf}, {63'd0, me.ov});
`endif
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk(in_ready === 1'b1, "in_ready_wait", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic wait_out(input string name);
    int n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk(n == NS, name, 64'(n), 64'(NS));
  endtask

  task automatic run_op(input logic [63:0] av, input logic [63:0] bv, input logic [63:0] ed,
                        input logic ebw, input logic eov, input bit hold);
    wait_ready();
    sb.push_back('{d: ed, bw: ebw, ov: eov});
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    a = ~av; b = 64'h0F1E_2D3C_4B5A_6978; in_valid = hold;
    wait_out("latency");
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk(in_ready === 1'b1, "reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk(out_valid === 1'b0, "reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk(diff === 64'd0, "reset_diff", diff, 64'd0);
    chk(borrow === 1'b0, "reset_borrow", {63'd0, borrow}, 64'd0);

    run_op(64'h0101010101010101, 64'h0101010101010101, 64'h0, 1'b0, 1'b0, 1'b1);
    run_op(64'h0, 64'h1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b0);
    run_op(64'h8000000000000000, 64'h1, 64'h7FFFFFFFFFFFFFFF, 1'b0, 1'b1, 1'b1);
    run_op(64'h0123456789ABCDEF, 64'h0, 64'h0123456789ABCDEF, 1'b0, 1'b0, 1'b1);
    run_op(64'h0100000000000000, 64'h1, 64'h00FFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b0);
    run_op(64'h7FFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1'b1, 1'b1, 1'b0);
    run_op(64'h1, 64'hFFFFFFFFFFFFFFFF, 64'h2, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;

    // Backpressure: result held while new operands wait on in_valid.
    out_ready = 1'b0;
    wait_ready();
    sb.push_back('{d: 64'd7, bw: 1'b0, ov: 1'b0});
    a = 64'd10; b = 64'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 64'd100; b = 64'd1;
    wait_out("bp_latency");
    for (int i = 0; i < 5; i++) begin
      chk(out_valid === 1'b1, "bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk(diff === 64'd7, "bp_diff_stable", diff, 64'd7);
      chk(borrow === 1'b0, "bp_borrow_stable", {63'd0, borrow}, 64'd0);
      chk(in_ready === 1'b0, "bp_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    sb.push_back('{d: 64'd99, bw: 1'b0, ov: 1'b0});
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk(in_ready === 1'b1, "bp_idle_after_ack", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk(in_ready === 1'b0, "bp_new_accepted", {63'd0, in_ready}, 64'd0);
    wait_out("bp2_latency");
    @(posedge clk); #1;

    // Reset during the third RUN cycle aborts the operation.
    wait_ready();
    a = 64'hAAAAAAAAAAAAAAAA; b = 64'h5555555555555555; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk(out_valid === 1'b0, "abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk(diff === 64'd0, "abort_diff", diff, 64'd0);
    chk(in_ready === 1'b1, "abort_in_ready", {63'd0, in_ready}, 64'd1);
    run_op(64'd5, 64'd3, 64'd2, 1'b0, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk(sb.size() == 0, "scoreboard_drained", 64'(sb.size()), 64'd0);

    begin
      int n = 0;
      while (!(gen[0].done && gen[1].done) && n < 60000) begin
        @(posedge clk); n++;
      end
      chk(gen[0].done && gen[1].done, "random_timeout", 64'(n), 64'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Back-to-back random traffic, out_ready tied high, reference is plain a - b.
  for (genvar gi = 0; gi < 2; gi++) begin : gen
    localparam int unsigned W   = (gi == 0) ? 16 : 64;
    localparam int unsigned NSG = 64 / W;

    logic        grst, iv, ir, ov_v, bw;
    logic [63:0] ga, gb, gd;
`ifdef CLA_SUB_OVF_EN
    logic        go;
`endif
    exp_t        q[$];
    exp_t        ge;
    bit          done = 1'b0;

    cla_sub_serial #(.SLICE_W(W)) u (
      .clk(clk), .rst(grst), .in_valid(iv), .in_ready(ir),
      .a(ga), .b(gb), .out_valid(ov_v), .out_ready(1'b1),
      .diff(gd), .borrow(bw)
`ifdef CLA_SUB_OVF_EN
      , .ovf(go)
`endif
    );

    always @(negedge clk) begin
      if (!grst && ov_v) begin
        if (q.size() == 0) begin
          chk(1'b0, $sformatf("w%0d_unexpected", W), gd, 64'd0);
        end else begin
          ge = q.pop_front();
          chk(gd === ge.d, $sformatf("w%0d_diff", W), gd, ge.d);
          chk(bw === ge.bw, $sformatf("w%0d_borrow", W), {63'd0, bw}, {63'd0, ge.bw});
`ifdef CLA_SUB_OVF_EN
          chk(go === ge.ov, $sformatf("w%0d_ovf", W), {63'd0, go}, {63'd0, ge.ov});
`endif
        end
      end
    end

    initial begin
      logic [63:0] x, y, d;
      int n;
      grst = 1'b1; iv = 1'b0; ga = '0; gb = '0;
      repeat (2) @(posedge clk);
      #1 grst = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        x = {$urandom(), $urandom()};
        y = {$urandom(), $urandom()};
        if (i % 10 == 3) y = x;
        d = x - y;
        q.push_back('{d: d, bw: (x < y), ov: (x[63] != y[63]) && (d[63] != x[63])});
        ga = x; gb = y; iv = 1'b1;
        n = 0;
        while (!ir && n < 10) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        ga = ~x; gb = ~y;
        n = 0;
        while (ov_v !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        chk(n == NSG, $sformatf("w%0d_latency", W), 64'(n), 64'(NSG));
      end
      @(posedge clk); #1;
      iv = 1'b0;
      repeat (2) @(posedge clk);
      done = 1'b1;
    end
  end

endmodule
